// File: rtl/des_block_streamer.sv
// Byte-stream packer/unpacker around the 64-bit DES decrypt core.
// Gathers 8 input bytes per block, kicks the core, then serialises the result as 8 bytes.
module des_block_streamer #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] des_key,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  output logic [63:0] core_message,
  output logic [63:0] core_key,
  output logic        core_enable,
  output logic        core_ack,
  input  logic        core_done,
  input  logic [63:0] core_result,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [15:0] blocks_done,
  output logic        error
);

  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_FILL,
    S_KICK,
    S_WAIT_LOW,
    S_WAIT_DONE,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [63:0]     msg_q, msg_d;
  logic [63:0]     key_q, key_d;
  logic [63:0]     out_sreg_q, out_sreg_d;
  logic            last_flag_q, last_flag_d;
  logic [2:0]      idx_q, idx_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0]     blocks_q, blocks_d;
  logic            error_q, error_d;

  logic            in_fire;
  logic            out_fire;
  logic            wait_expired;
  logic [63:0]     msg_fill;

  // Incoming byte lands in its slot; a short final block pads every later slot.
  for (genvar gi = 0; gi < 8; gi++) begin : g_slot
    assign msg_fill[63-8*gi -: 8] =
        (byte_cnt_q == 3'(gi))             ? in_byte  :
        (in_last && (byte_cnt_q < 3'(gi))) ? PAD_BYTE :
                                             msg_q[63-8*gi -: 8];
  end

  assign in_ready     = (state_q == S_FILL) && !reset;
  assign in_fire      = in_valid && in_ready;
  assign out_valid    = (state_q == S_DRAIN);
  assign out_fire     = out_valid && out_ready;
  assign out_byte     = out_sreg_q[63:56];
  assign out_last     = out_valid && last_flag_q && (idx_q == 3'd7);
  assign core_ack     = (state_q == S_KICK);
  assign core_enable  = (state_q == S_KICK) || (state_q == S_WAIT_LOW) ||
                        (state_q == S_WAIT_DONE);
  assign core_message = msg_q;
  assign core_key     = key_q;
  assign blocks_done  = blocks_q;
  assign error        = error_q;
  assign wait_expired = (wait_cnt_q == WCW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    msg_d       = msg_q;
    key_d       = key_q;
    out_sreg_d  = out_sreg_q;
    last_flag_d = last_flag_q;
    idx_d       = idx_q;
    wait_cnt_d  = wait_cnt_q;
    blocks_d    = blocks_q;
    error_d     = error_q;
    case (state_q)
      S_FILL: begin
        if (in_fire) begin
          msg_d      = msg_fill;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if ((byte_cnt_q == 3'd7) || in_last) begin
            key_d       = des_key;
            last_flag_d = in_last;
            state_d     = S_KICK;
          end
        end
      end
      S_KICK: begin
        wait_cnt_d = '0;
        byte_cnt_d = 3'd0;
        state_d    = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        // A done still high here belongs to the previous run and is ignored.
        wait_cnt_d = wait_cnt_q + WCW'(1);
        if (wait_expired) begin
          error_d = 1'b1;
          state_d = S_FILL;
        end else if (!core_done) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
        if (wait_expired) begin
          error_d = 1'b1;
          state_d = S_FILL;
        end else if (core_done) begin
          out_sreg_d = core_result;
          idx_d      = 3'd0;
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          out_sreg_d = {out_sreg_q[55:0], 8'h00};
          idx_d      = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            blocks_d   = blocks_q + 16'd1;
            byte_cnt_d = 3'd0;
            state_d    = S_FILL;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FILL;
      byte_cnt_q  <= 3'd0;
      msg_q       <= '0;
      key_q       <= '0;
      out_sreg_q  <= '0;
      last_flag_q <= 1'b0;
      idx_q       <= 3'd0;
      wait_cnt_q  <= '0;
      blocks_q    <= 16'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      msg_q       <= msg_d;
      key_q       <= key_d;
      out_sreg_q  <= out_sreg_d;
      last_flag_q <= last_flag_d;
      idx_q       <= idx_d;
      wait_cnt_q  <= wait_cnt_d;
      blocks_q    <= blocks_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_des_block_streamer.sv
// Randomised bench for des_block_streamer with a done/ack core model and a
// queue-based expectation of kicked blocks and drained bytes.
module tb_des_block_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] des_key = '0;
  logic [7:0]  in_byte = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [63:0] core_message;
  logic [63:0] core_key;
  logic        core_enable;
  logic        core_ack;
  logic        core_done = 1'b0;
  logic [63:0] core_result = '0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [15:0] blocks_done;
  logic        error;

  des_block_streamer dut (
    .clk          (clk),
    .reset        (reset),
    .des_key      (des_key),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .core_message (core_message),
    .core_key     (core_key),
    .core_enable  (core_enable),
    .core_ack     (core_ack),
    .core_done    (core_done),
    .core_result  (core_result),
    .out_byte     (out_byte),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .blocks_done  (blocks_done),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Core model: done stays high until ack, may linger a few cycles after ack
  // (stale), then drops, then rises with result = message ^ all-ones.
  logic        hang = 1'b0;
  int          stale_min = 0;
  logic        busy = 1'b0;
  int          stale_cnt = 0;
  int          lat_cnt = 0;
  logic [63:0] lat_msg = '0;

  always @(posedge clk) begin
    if (reset) begin
      core_done   <= 1'b0;
      core_result <= '0;
      busy        <= 1'b0;
      stale_cnt   <= 0;
      lat_cnt     <= 0;
    end else if (core_ack) begin
      lat_msg   <= core_message;
      stale_cnt <= $urandom_range(3, stale_min);
      lat_cnt   <= $urandom_range(12, 1);
      busy      <= 1'b1;
    end else if (busy) begin
      if (stale_cnt != 0) begin
        stale_cnt <= stale_cnt - 1;
      end else if (lat_cnt != 0) begin
        core_done <= 1'b0;
        if (!hang) lat_cnt <= lat_cnt - 1;
      end else begin
        core_done   <= 1'b1;
        core_result <= lat_msg ^ 64'hFFFF_FFFF_FFFF_FFFF;
        busy        <= 1'b0;
      end
    end
  end

  int          checks = 0;
  int          fails = 0;
  logic [63:0] exp_msg[$];
  logic [63:0] exp_key[$];
  logic [9:0]  exp_out[$];   // {end_of_block, last, byte}
  logic [8:0]  out_log[$];   // {out_last, out_byte}
  logic [15:0] exp_blocks = 16'd0;
  logic [63:0] last_msg = '0;
  logic        prev_ack = 1'b0;
  logic        stall_hold = 1'b0;
  logic [7:0]  held_byte = '0;
  int          wait_cycles = 0;
  logic        in_acc = 1'b0;
  logic        rdy_hold = 1'b0;
  logic        rdy_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic monitor();
    logic [9:0]  e;
    logic [63:0] m;
    if (reset) begin
      exp_msg.delete();
      exp_key.delete();
      exp_out.delete();
      exp_blocks = 16'd0;
      prev_ack   = 1'b0;
      stall_hold = 1'b0;
      return;
    end
    chk("blocks_done", 64'(blocks_done), 64'(exp_blocks));
    chk("in_out_disjoint", 64'(in_ready & out_valid), 64'd0);
    if (core_ack) begin
      chk("ack_pulse_width", 64'(prev_ack), 64'd0);
      last_msg    = core_message;
      wait_cycles = 0;
      $display("kick msg=%h key=%h", core_message, core_key);
      if (exp_msg.size() == 0) begin
        chk("unexpected_kick", 64'd1, 64'd0);
      end else begin
        m = exp_msg.pop_front();
        chk("core_message", core_message, m);
        m = exp_key.pop_front();
        chk("core_key", core_key, m);
      end
    end else if (core_enable) begin
      wait_cycles++;
    end
    prev_ack = core_ack;
    if (out_valid) begin
      if (stall_hold) chk("stall_stable", 64'(out_byte), 64'(held_byte));
      if (out_ready) begin
        stall_hold = 1'b0;
        out_log.push_back({out_last, out_byte});
        if (exp_out.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = exp_out.pop_front();
          chk("out_byte", 64'(out_byte), 64'(e[7:0]));
          chk("out_last", 64'(out_last), 64'(e[8]));
          if (e[9]) exp_blocks = exp_blocks + 16'd1;
        end
      end else begin
        stall_hold = 1'b1;
        held_byte  = out_byte;
      end
    end else begin
      stall_hold = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    in_acc = in_valid && in_ready;
    monitor();
    @(posedge clk);
    #1;
    if (rdy_q.size() > 0) out_ready = rdy_q.pop_front();
    else if (rdy_hold)    out_ready = 1'b0;
    else                  out_ready = ($urandom_range(3, 0) != 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int g;
    in_valid = 1'b0;
    repeat ($urandom_range(2, 0)) tick();
    in_byte  = b;
    in_last  = l;
    in_valid = 1'b1;
    g = 0;
    do begin
      tick();
      g++;
    end while (!in_acc && g < 3000);
    chk("byte_accept_timeout", 64'(in_acc), 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_byte  = 8'($urandom);
  endtask

  task automatic send_block(input int n, input logic lastf, input logic [7:0] b [8],
                            input logic expect_out);
    logic [63:0] m;
    logic [63:0] r;
    des_key = {$urandom, $urandom};
    m = '0;
    for (int i = 0; i < 8; i++) m[63-8*i -: 8] = (i < n) ? b[i] : 8'h00;
    exp_msg.push_back(m);
    exp_key.push_back(des_key);
    if (expect_out) begin
      r = ~m;
      for (int i = 0; i < 8; i++)
        exp_out.push_back({(i == 7), (i == 7) && lastf, r[63-8*i -: 8]});
    end
    for (int i = 0; i < n; i++) send_byte(b[i], (i == n - 1) && lastf);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      tick();
      g++;
    end while (!(exp_out.size() == 0 && exp_msg.size() == 0 && in_ready) && g < 4000);
    chk("idle_timeout", 64'(g < 4000), 64'd1);
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_core_ack", 64'(core_ack), 64'd0);
    chk("rst_core_enable", 64'(core_enable), 64'd0);
    chk("rst_blocks_done", 64'(blocks_done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_core_message", core_message, 64'd0);
    chk("rst_core_key", core_key, 64'd0);
  endtask

  initial begin
    logic [7:0] blk [8];
    int         n;
    int         g;
    logic       lastf;

    reset = 1'b1;
    tick();
    tick();
    check_reset_state();
    reset = 1'b0;
    tick();
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // T1: bytes 01..08, last on 08
    for (int i = 0; i < 8; i++) blk[i] = 8'(i + 1);
    out_log.delete();
    send_block(8, 1'b1, blk, 1'b1);
    wait_idle();
    chk("t1_message", last_msg, 64'h0102030405060708);
    chk("t1_log_size", 64'(out_log.size()), 64'd8);
    if (out_log.size() == 8) begin
      chk("t1_first_byte", 64'(out_log[0]), 64'h0FE);
      chk("t1_last_byte", 64'(out_log[7]), 64'h1F7);
    end
    chk("t1_blocks_done", 64'(blocks_done), 64'd1);

    // T2: short block AA BB CC
    blk[0] = 8'hAA; blk[1] = 8'hBB; blk[2] = 8'hCC;
    out_log.delete();
    send_block(3, 1'b1, blk, 1'b1);
    wait_idle();
    chk("t2_message", last_msg, 64'hAABBCC0000000000);
    chk("t2_log_size", 64'(out_log.size()), 64'd8);
    if (out_log.size() == 8) begin
      chk("t2_first_byte", 64'(out_log[0]), 64'h055);
      chk("t2_pad_byte", 64'(out_log[3]), 64'h0FF);
      chk("t2_last_byte", 64'(out_log[7]), 64'h1FF);
    end

    // T3: stall pattern 1-0-0-1 during drain
    for (int i = 0; i < 8; i++) blk[i] = 8'($urandom);
    rdy_hold  = 1'b1;
    out_ready = 1'b0;
    out_log.delete();
    send_block(8, 1'b0, blk, 1'b1);
    g = 0;
    while (!out_valid && g < 200) begin
      tick();
      g++;
    end
    chk("t3_drain_reached", 64'(out_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
      rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    end
    rdy_hold = 1'b0;
    wait_idle();
    chk("t3_log_size", 64'(out_log.size()), 64'd8);

    // Randomised traffic, back-to-back blocks
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(8, 1);
      lastf = (n < 8) ? 1'b1 : 1'($urandom_range(1, 0));
      for (int i = 0; i < 8; i++) blk[i] = 8'($urandom);
      send_block(n, lastf, blk, 1'b1);
      if ($urandom_range(3, 0) == 0) wait_idle();
    end
    wait_idle();

    // T6: stale done held high after ack for 3 cycles
    stale_min = 3;
    for (int i = 0; i < 8; i++) blk[i] = 8'(8'h11 + i);
    out_log.delete();
    send_block(8, 1'b1, blk, 1'b1);
    wait_idle();
    stale_min = 0;
    chk("t6_message", last_msg, 64'h1112131415161718);
    if (out_log.size() == 8) chk("t6_first_byte", 64'(out_log[0]), 64'h0EE);
    else chk("t6_log_size", 64'(out_log.size()), 64'd8);

    // T4: core never completes
    chk("t4_error_before", 64'(error), 64'd0);
    hang = 1'b1;
    for (int i = 0; i < 8; i++) blk[i] = 8'($urandom);
    send_block(8, 1'b1, blk, 1'b0);
    g = 0;
    while (!error && g < 1500) begin
      tick();
      g++;
    end
    chk("t4_error_set", 64'(error), 64'd1);
    chk("t4_wait_cycles", 64'(wait_cycles), 64'd1023);
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    hang = 1'b0;
    for (int i = 0; i < 8; i++) blk[i] = 8'($urandom);
    send_block(5, 1'b1, blk, 1'b1);
    wait_idle();
    chk("t4_error_sticky", 64'(error), 64'd1);

    // T5: reset in the middle of a block
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    reset = 1'b1;
    tick();
    check_reset_state();
    reset = 1'b0;
    tick();
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 8; i++) blk[i] = 8'($urandom);
    send_block(8, 1'b1, blk, 1'b1);
    wait_idle();
    chk("t5_blocks_done", 64'(blocks_done), 64'd1);
    chk("t5_error", 64'(error), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
